// File: rtl/timer_sequencer.sv
// Upstream controller for the countdown timer: steps the timer through a small
// program of intervals, with one-shot/looping runs, abort and a per-interval watchdog.
module timer_sequencer #(
    parameter int DEPTH = 4,
    parameter int CW    = 4,
    parameter int TMO_W = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [CW-1:0] wr_data,
    input  logic [AW:0]   num_steps,
    input  logic          go,
    input  logic          loop,
    input  logic          abort,
    input  logic          timer_reached,
    output logic [CW-1:0] count_out,
    output logic          start_out,
    output logic          busy,
    output logic [AW-1:0] step_idx,
    output logic          step_pulse,
    output logic          done,
    output logic          timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT
    } state_t;

    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    state_t           state_q;
    logic [CW-1:0]    prog_q [DEPTH];
    logic [AW:0]      nsteps_q;
    logic [AW:0]      nsteps_d;
    logic [TMO_W-1:0] wdog_q;
    logic [CW-1:0]    count_q;
    logic             start_q;
    logic             busy_q;
    logic [AW-1:0]    idx_q;
    logic [AW-1:0]    idx_d;
    logic             pulse_q;
    logic             done_q;
    logic             tmo_q;

    logic             go_acc;
    logic             wr_acc;
    logic             last_step;
    logic             wdog_max;

    // A write coinciding with an accepted go is dropped so the run starts
    // from the program as it stood before the go.
    always_comb begin
        nsteps_d  = (num_steps > DEPTH_N) ? DEPTH_N : num_steps;
        go_acc    = (state_q == S_IDLE) && go && (nsteps_d != '0);
        wr_acc    = wr_en && !busy_q && !go_acc;
        idx_d     = idx_q + AW'(1);
        last_step = (({1'b0, idx_q} + (AW+1)'(1)) == nsteps_q);
        wdog_max  = &wdog_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            nsteps_q <= '0;
            wdog_q   <= '0;
            count_q  <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            idx_q    <= '0;
            pulse_q  <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                prog_q[i] <= '0;
            end
        end else begin
            pulse_q <= 1'b0;
            done_q  <= 1'b0;

            if (wr_acc) begin
                prog_q[wr_addr] <= wr_data;
            end

            case (state_q)
                S_IDLE: begin
                    if (go_acc) begin
                        nsteps_q <= nsteps_d;
                        idx_q    <= '0;
                        count_q  <= prog_q[0];
                        busy_q   <= 1'b1;
                        tmo_q    <= 1'b0;
                        state_q  <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (abort) begin
                        start_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        start_q <= 1'b1;
                        wdog_q  <= '0;
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (abort) begin
                        start_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (timer_reached) begin
                        // Completion wins over a watchdog expiring on the same edge.
                        pulse_q <= 1'b1;
                        start_q <= 1'b0;
                        if (!last_step) begin
                            idx_q   <= idx_d;
                            count_q <= prog_q[idx_d];
                            state_q <= S_LOAD;
                        end else if (loop) begin
                            idx_q   <= '0;
                            count_q <= prog_q[0];
                            state_q <= S_LOAD;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else if (wdog_max) begin
                        tmo_q   <= 1'b1;
                        start_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + TMO_W'(1);
                    end
                end

                default: begin
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign count_out   = count_q;
    assign start_out   = start_q;
    assign busy        = busy_q;
    assign step_idx    = idx_q;
    assign step_pulse  = pulse_q;
    assign done        = done_q;
    assign timeout_err = tmo_q;

endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Upstream controller for the countdown timer stage. Holds a small program of interval values and drives the timer's `count` and `start` inputs one interval at a time. It consumes the timer's `timer_reached` to advance to the next interval. It supports one-shot or looping sequences, a synchronous abort, and a per-interval watchdog that flags a timer that never reports completion.

## Interface
Parameters:
- `DEPTH`, 4: number of program entries (power of two, ≥2).
- `CW`, 4: interval/count width; matches timer count input.
- `TMO_W`, 8: watchdog width; an interval times out after 2^TMO_W WAIT cycles.

Ports (AW = clog2(DEPTH)):
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  program write strobe; honoured only when `busy`=0.
- `wr_addr`  in  AW  program entry index.
- `wr_data`  in  CW  interval value to store.
- `num_steps`  in  AW+1  entries to run, sampled on `go`; 0 = `go` ignored; >DEPTH clamps to DEPTH.
- `go`  in  1  start sequence; honoured only in IDLE.
- `loop`  in  1  sampled at completion of the last step; 1 = restart at entry 0.
- `abort`  in  1  stop sequence; return to IDLE next edge.
- `timer_reached`  in  1  completion flag from the timer stage.
- `count_out`  out  CW  interval presented to the timer.
- `start_out`  out  1  timer enable.
- `busy`  out  1  sequence in progress.
- `step_idx`  out  AW  current program entry.
- `step_pulse`  out  1  one-cycle pulse per completed interval.
- `done`  out  1  one-cycle pulse at end of a non-looping sequence.
- `timeout_err`  out  1  sticky watchdog flag; cleared by `rst` or by an accepted `go`.

## Operation
- All outputs are registered. Reset values:
  - `count_out`=0, `start_out`=0, `busy`=0, `step_idx`=0, `step_pulse`=0, `done`=0, `timeout_err`=0.
  - State = IDLE; all program entries = 0; watchdog = 0.
- States:
  - IDLE: `start_out`=0, `busy`=0.
    - `go`=1 with effective steps N≥1: latch N; set `step_idx`=0, `count_out`=prog[0], `busy`=1, `timeout_err`=0; go to LOAD.
  - LOAD: one cycle with `start_out`=0. Next edge: `start_out`=1, watchdog=0, go to WAIT.
  - WAIT: `start_out`=1. Each edge with `timer_reached`=0 increments the watchdog.
    - `timer_reached`=1: `step_pulse`=1 and `start_out`=0.
      - If `step_idx`<N-1: increment `step_idx`, load the next entry into `count_out`, go to LOAD.
      - Else if `loop`=1: `step_idx`=0, `count_out`=prog[0], go to LOAD.
      - Else: `done`=1, `busy`=0, go to IDLE.
    - Watchdog reaches 2^TMO_W-1 with `timer_reached`=0: `timeout_err`=1, `start_out`=0, `busy`=0, go to IDLE.
- Priority, highest first: `rst` > `abort` > `timer_reached` > watchdog timeout.
- `abort` in LOAD or WAIT: next edge IDLE, `start_out`=0, `busy`=0; no `done`, no `step_pulse`. `abort` in IDLE has no effect.
- `go` while busy is ignored. Writes while busy are dropped and the program is unchanged.
- A write in the same cycle as an accepted `go` is dropped; `go` takes effect.
- `count_out` and `step_idx` hold their last values in IDLE.
- `num_steps` is latched at `go` only; later changes have no effect on a running sequence.

## Timing
- Accepted `go` at edge E:
  - `busy`=1 and `count_out` valid after E.
  - `start_out` rises after E+1.
- `timer_reached` sampled high at edge M:
  - `start_out` low after M.
  - The next `count_out` is valid after M.
  - `start_out` high again after M+1. `start_out` is low for exactly one cycle between intervals.
- `step_pulse` and `done` are high for the single cycle after M.
- Timeout: an interval held in WAIT for 2^TMO_W edges without `timer_reached` raises `timeout_err` after the last of those edges.
- `rst` mid-sequence: all outputs and the program return to reset values at the next edge.

## Test plan
- Reset check: after `rst`, all outputs read 0. Holding `go`=1 with `num_steps`=0 leaves `busy`=0.
- One-shot run: program {3,5,2,7}, `num_steps`=3, pulse `go`, timer model asserts `timer_reached` 4 cycles after each `start_out` rise.
  - `count_out` sequence is 3,5,2.
  - Three `step_pulse`s, one `done`.
  - `start_out` low exactly 1 cycle between intervals.
  - `busy` drops with `done`.
- Loop: same program, `num_steps`=2, `loop`=1.
  - `count_out` follows 3,5,3,5.
  - Clearing `loop` during the second pass ends with `done` after entry 1.
- Abort: assert `abort` during WAIT of step 1.
  - `start_out`=0 and `busy`=0 next edge; no `done`.
  - A write to entry 0 now succeeds.
- Watchdog: `TMO_W`=4, `timer_reached` held 0. `timeout_err`=1 after 16 WAIT edges; it stays set until the next accepted `go`.
- Collisions:
  - `timer_reached` on the final watchdog edge: step advances, no `timeout_err`.
  - Write during `busy` is ignored (read back via a later run).
  - `go` during `busy` does not restart the sequence.
